// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load extender.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

  localparam logic [1:0] LD_BYTE  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_WORD  = 2'b10;
  localparam logic [1:0] LD_DWORD = 2'b11;

  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/load_extend.sv
// Aligns a loaded doubleword by byte offset, then sign/zero-extends it to the load size.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_signed,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Bytes shifted in from above the doubleword read as zero.
  assign shifted = data >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    unique case (size)
      LD_BYTE:  result = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
      LD_HALF:  result = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
      LD_WORD:  result = {{(XLEN-32){is_signed & shifted[31]}}, shifted[31:0]};
      LD_DWORD: result = shifted;
      default:  result = shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring ops, waits for load data, drives the register bank port.
// Optional macro WB_BYPASS_EN exposes the registered write port as a decode bypass.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   DataC,
  output logic [REG_AW-1:0] c,
  output logic              w,
  output logic              err_spurious,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);

  localparam logic [REG_AW-1:0] Xzr = REG_AW'(XZR_IDX);

  wb_state_e         state_q, state_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [2:0]        off_q, off_d;
  logic [REG_AW-1:0] c_q, c_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   ext_data;
  logic              accept;

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .data      (mem_rdata),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .result    (ext_data)
  );

  assign in_ready = (state_q != WAIT_MEM);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    size_d     = size_q;
    signed_d   = signed_q;
    off_d      = off_q;
    c_d        = c_q;
    data_d     = data_q;
    err_d      = err_q;

    unique case (state_q)
      WAIT_MEM: begin
        if (mem_rvalid) begin
          if (regwrite_q && (rd_q != Xzr)) begin
            state_d = WRITE;
            c_d     = rd_q;
            data_d  = ext_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        // IDLE and WRITE behave identically: each may accept a new op.
        err_d   = err_q | mem_rvalid;
        state_d = IDLE;
        if (accept) begin
          if (in_memtoreg) begin
            state_d    = WAIT_MEM;
            rd_d       = in_rd;
            regwrite_d = in_regwrite;
            size_d     = in_ld_size;
            signed_d   = in_ld_signed;
            off_d      = in_alu_result[2:0];
          end else if (in_regwrite && (in_rd != Xzr)) begin
            state_d = WRITE;
            c_d     = in_rd;
            data_d  = in_alu_result;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      size_q     <= LD_BYTE;
      signed_q   <= 1'b0;
      off_q      <= '0;
      c_q        <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      off_q      <= off_d;
      c_q        <= c_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  // WRITE lasts one cycle, so the write strobe is simply the registered state.
  assign w            = (state_q == WRITE);
  assign c            = c_q;
  assign DataC        = data_q;
  assign err_spurious = err_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid = w;
  assign fwd_rd    = c_q;
  assign fwd_data  = data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus random traffic against a behavioural model.
module tb_wb_stage;

  logic        Clk;
  logic        Rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [63:0] in_alu_result;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [63:0] DataC;
  logic [4:0]  c;
  logic        w;
  logic        err_spurious;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;

  int n_checks = 0;
  int n_pass   = 0;

  wb_stage #(
    .XLEN   (64),
    .REG_AW (5)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_regwrite   (in_regwrite),
    .in_memtoreg   (in_memtoreg),
    .in_alu_result (in_alu_result),
    .in_ld_size    (in_ld_size),
    .in_ld_signed  (in_ld_signed),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .DataC         (DataC),
    .c             (c),
    .w             (w),
    .err_spurious  (err_spurious),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Byte-by-byte load semantics: bytes beyond the doubleword read as zero.
  function automatic logic [63:0] ref_load(input logic [63:0] dw, input int off, input int size,
                                           input bit sgn);
    logic [63:0] v;
    int nbytes;
    v = 0;
    nbytes = 1 << size;
    for (int i = 0; i < nbytes; i++)
      if (off + i < 8) v = v | (((dw >> (8 * (off + i))) & 64'hFF) << (8 * i));
    if (sgn && size != 3 && v[8*nbytes-1]) v = v | (~64'd0 << (8 * nbytes));
    return v;
  endfunction

  // Behavioural model: a pending load blocks intake; a write appears the cycle after its cause.
  bit          m_pend;
  logic [4:0]  m_prd;
  bit          m_preg;
  int          m_psize;
  bit          m_psgn;
  int          m_poff;
  bit          m_w;
  logic [4:0]  m_c;
  logic [63:0] m_data;
  bit          m_err;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_pend = 0; m_w = 0; m_c = 0; m_data = 0; m_err = 0;
    end else begin
      bit nw;
      nw = 0;
      if (m_pend) begin
        if (mem_rvalid) begin
          m_pend = 0;
          if (m_preg && m_prd != 5'd31) begin
            nw = 1; m_c = m_prd; m_data = ref_load(mem_rdata, m_poff, m_psize, m_psgn);
          end
        end
      end else begin
        if (mem_rvalid) m_err = 1;
        if (in_valid) begin
          if (in_memtoreg) begin
            m_pend = 1; m_prd = in_rd; m_preg = in_regwrite; m_psize = int'(in_ld_size);
            m_psgn = in_ld_signed; m_poff = int'(in_alu_result[2:0]);
          end else if (in_regwrite && in_rd != 5'd31) begin
            nw = 1; m_c = in_rd; m_data = in_alu_result;
          end
        end
      end
      m_w = nw;
    end
  end

  always @(negedge Clk) begin
    check("in_ready", in_ready, !m_pend);
    check("w", w, m_w);
    check("err_spurious", err_spurious, m_err);
    if (m_w) begin
      check("c", c, m_c);
      check("DataC", DataC, m_data);
      check("w_c_xzr", (c == 5'd31), 0);
    end
    if (!Rst_n) begin
      check("rst_c", c, 0);
      check("rst_DataC", DataC, 0);
    end
`ifdef WB_BYPASS_EN
    check("fwd_valid", fwd_valid, m_w);
    if (m_w) begin
      check("fwd_rd", fwd_rd, m_c);
      check("fwd_data", fwd_data, m_data);
    end
`else
    check("fwd_valid", fwd_valid, 0);
    check("fwd_rd", fwd_rd, 0);
    check("fwd_data", fwd_data, 0);
`endif
  end

  task automatic idle_in();
    in_valid = 0; in_regwrite = 0; in_memtoreg = 0; in_rd = 0;
    in_alu_result = 0; in_ld_size = 0; in_ld_signed = 0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [63:0] res);
    in_valid = 1; in_regwrite = 1; in_memtoreg = 0; in_rd = rd; in_alu_result = res;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [63:0] addr, input logic [1:0] sz,
                            input logic sgn);
    in_valid = 1; in_regwrite = 1; in_memtoreg = 1; in_rd = rd; in_alu_result = addr;
    in_ld_size = sz; in_ld_signed = sgn;
  endtask

  task automatic do_reset();
    Rst_n = 0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1;
  endtask

  initial begin
    idle_in();
    mem_rvalid = 0; mem_rdata = 0; Rst_n = 0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1;
    @(negedge Clk);
    check("lit_rst_w", w, 0);
    check("lit_rst_err", err_spurious, 0);
    check("lit_rst_ready", in_ready, 1);

    // ALU write
    @(posedge Clk); #1 drive_alu(5'd5, 64'h1234);
    @(posedge Clk); #1 idle_in();
    @(negedge Clk);
    check("lit_alu_w", w, 1);
    check("lit_alu_c", c, 5);
    check("lit_alu_data", DataC, 64'h1234);
`ifdef WB_BYPASS_EN
    check("lit_alu_fwd", fwd_data, 64'h1234);
`else
    check("lit_alu_fwd", fwd_data, 0);
`endif
    @(negedge Clk);
    check("lit_alu_w_off", w, 0);

    // Signed byte load at offset 3; an upstream op collides with rvalid and must be refused
    @(posedge Clk); #1 drive_load(5'd9, 64'h1003, 2'b00, 1'b1);
    @(posedge Clk); #1 idle_in();
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("lit_ld_ready", in_ready, 0);
      @(posedge Clk); #1;
    end
    mem_rvalid = 1; mem_rdata = 64'h00000000_80000000;
    drive_alu(5'd7, 64'hDEAD);
    @(negedge Clk);
    check("lit_ld_ready_rv", in_ready, 0);
    @(posedge Clk); #1 mem_rvalid = 0; idle_in();
    @(negedge Clk);
    check("lit_ld_w", w, 1);
    check("lit_ld_c", c, 9);
    check("lit_ld_data", DataC, 64'hFFFFFFFF_FFFFFF80);
    @(negedge Clk);
    check("lit_ld_w_off", w, 0);

    // XZR suppression for ALU and load
    @(posedge Clk); #1 drive_alu(5'd31, 64'h55);
    @(negedge Clk);
    check("lit_xzr_ready", in_ready, 1);
    @(posedge Clk); #1 drive_load(5'd31, 64'h0, 2'b11, 1'b0);
    @(negedge Clk);
    check("lit_xzr_alu_w", w, 0);
    @(posedge Clk); #1 idle_in(); mem_rvalid = 1; mem_rdata = 64'h1111;
    @(posedge Clk); #1 mem_rvalid = 0;
    @(negedge Clk);
    check("lit_xzr_ld_w", w, 0);
    check("lit_xzr_ld_ready", in_ready, 1);

    // Back-to-back ALU ops
    @(posedge Clk); #1 drive_alu(5'd1, 64'h111);
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clk); #1;
      if (i < 4) drive_alu(5'(i + 1), 64'(i + 1) * 64'h111);
      else idle_in();
      @(negedge Clk);
      check("lit_b2b_w", w, 1);
      check("lit_b2b_c", c, 5'(i));
      check("lit_b2b_ready", in_ready, 1);
    end

    // Reset mid-load, then a late rvalid
    @(posedge Clk); #1 drive_load(5'd12, 64'h8, 2'b10, 1'b0);
    @(posedge Clk); #1 idle_in();
    @(negedge Clk);
    check("lit_rml_ready", in_ready, 0);
    #2 Rst_n = 0;
    @(posedge Clk); #1 Rst_n = 1; mem_rvalid = 1; mem_rdata = 64'hABCD;
    @(posedge Clk); #1 mem_rvalid = 0;
    @(negedge Clk);
    check("lit_rml_err", err_spurious, 1);
    check("lit_rml_w", w, 0);
    check("lit_rml_ready", in_ready, 1);

    // Random traffic
    @(posedge Clk); #1 do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk); #1;
      if (cyc == 1500) begin
        Rst_n = 0;
        @(posedge Clk); #1 Rst_n = 1;
      end
      in_valid      = ($urandom_range(0, 3) != 0);
      in_rd         = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom);
      in_regwrite   = ($urandom_range(0, 4) != 0);
      in_memtoreg   = ($urandom_range(0, 2) == 0);
      in_alu_result = {$urandom, $urandom};
      in_ld_size    = 2'($urandom);
      in_ld_signed  = 1'($urandom);
      mem_rdata     = {$urandom, $urandom};
      mem_rvalid    = m_pend ? ($urandom_range(0, 2) == 0)
                             : (cyc > 2500 && $urandom_range(0, 49) == 0);
    end
    @(posedge Clk); #1 idle_in(); mem_rvalid = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
